stage3_exec: RTL and testbench
==============================

STAGE3_EXEC -- requirements
Module: stage3_exec

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low (acts on negedge rst).
REQ-004 r1, r2  in  32 each  source operands from the ID/EX register.
REQ-005 rd  in  5  destination register.
REQ-006 imm  in  32  sign-extended immediate.
REQ-007 PC  in  32  instruction address.
REQ-008 op_data  in  11  control: [3:0] alu_op, [4] alu_src_imm, [5] use_pc, [6] muldiv, [7] reg_write, [8] mem_read, [9] mem_write, [10] branch.
REQ-009 flush  in  1  kill current instruction, including any muldiv in progress.
REQ-010 stall  out  1  combinational; high holds the ID/EX register (upstream en = !stall).
REQ-011 alu_result_out  out  32  registered result.
REQ-012 r2_out  out  32  registered store data (r2).
REQ-013 rd_out  out  5  registered destination.
REQ-014 op_data_out  out  11  registered control.
REQ-015 branch_taken_out  out  1  registered: branch && r1==r2.
REQ-016 branch_target_out  out  32  registered PC+imm, mod 2^32.

Function
REQ-017 A = use_pc ? PC : r1; B = alu_src_imm ? imm : r2.
REQ-018 alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift by B[4:0]), 8 SLT signed, 9 SLTU, 10 PASS B; 11-15 give 0. Arithmetic wraps mod 2^32.
REQ-019 Non-muldiv ops: one-cycle latency. All outputs load at the posedge following presentation; stall stays 0.
REQ-020 Muldiv ops use alu_op[1:0]: 00 MUL (low 32 bits), 01 MULH (signed x signed, high 32), 10 DIV (signed), 11 REM (signed). Each is computed by an iterative unit doing one bit per cycle, 32 iterations.
REQ-021 FSM states IDLE, BUSY, DONE. IDLE->BUSY when muldiv=1: operands captured and count=0. BUSY: count increments each edge; BUSY->DONE on the edge where count=31. DONE->IDLE unconditionally, and muldiv is ignored while in DONE.
REQ-022 stall = (IDLE && muldiv && !flush) || BUSY. Stall is 0 in DONE.
REQ-023 While IDLE-with-muldiv or BUSY, each edge writes a bubble: all outputs 0.
REQ-024 On the edge leaving DONE, the muldiv result plus r2, rd, op_data, branch fields of the held instruction are written. Muldiv total = 34 edges from presentation; stall high for 33 cycles.
REQ-025 Divide by zero: DIV = 0xFFFFFFFF, REM = dividend. Overflow 0x80000000 / 0xFFFFFFFF: DIV = 0x80000000, REM = 0.
REQ-026 Signed ops: magnitudes are computed, then sign is corrected. REM takes the dividend's sign.
REQ-027 flush=1 at an edge: outputs written as bubble and FSM goes to IDLE from any state. flush takes priority over DONE completion and over a new muldiv start.

Reset
REQ-028 rst=0 immediately forces: all registered outputs 0, FSM IDLE, count 0, operand/accumulator registers 0. This applies mid-operation too, and no partial result is ever output.
REQ-029 After rst returns high, the first edge behaves as IDLE.

Configuration
REQ-030 Macro MULDIV_EN: when defined, the FSM and iterative unit are built per REQ-020..027.
REQ-031 Without MULDIV_EN: no FSM or unit is built; stall is tied to 0; muldiv ops complete in one cycle with alu_result_out=0 and other fields passed through normally.

Verification
REQ-032 ADD: r1=5, r2=7, alu_op=0 -> next edge alu_result_out=12, stall 0 throughout.
REQ-033 SRA via imm: r1=0x80000000, alu_src_imm=1, imm=4, alu_op=7 -> 0xF8000000. SLT -1<1 -> 1; SLTU -> 0.
REQ-034 DIV -7/2 (MULDIV_EN) -> stall high 33 cycles, bubbles, then -3 on 34th edge. REM -> -1. DIV x/0 -> 0xFFFFFFFF.
REQ-035 MULH 0x80000000 x 0x80000000 -> 0x40000000. MUL 0xFFFFFFFF x 3 -> 0xFFFFFFFD. A following ADD completes one edge later.
REQ-036 flush at BUSY count 10 -> stall low next cycle, outputs 0. Separately, rst low at count 20 -> all outputs 0 immediately, FSM IDLE.
REQ-037 Branch: branch=1, r1=r2=9, PC=0x100, imm=-8 -> branch_taken_out=1, branch_target_out=0xF8.

Source files
------------

// File: rtl/stage3_exec.sv
// Execute stage: single-cycle ALU plus an optional bit-serial multiply/divide unit.
// Define MULDIV_EN to build the iterative MUL/MULH/DIV/REM unit; otherwise muldiv ops yield 0.
module stage3_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  input  logic [31:0] PC,
  input  logic [10:0] op_data,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] alu_result_out,
  output logic [31:0] r2_out,
  output logic [4:0]  rd_out,
  output logic [10:0] op_data_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_target_out
);

  logic [3:0]  w_alu_op;
  logic        w_muldiv;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic        w_kill;

  assign w_alu_op = op_data[3:0];
  assign w_muldiv = op_data[6];
  assign w_a      = op_data[5] ? PC  : r1;
  assign w_b      = op_data[4] ? imm : r2;

  always_comb begin
    w_alu = 32'd0;
    case (w_alu_op)
      4'd0:    w_alu = w_a + w_b;
      4'd1:    w_alu = w_a - w_b;
      4'd2:    w_alu = w_a & w_b;
      4'd3:    w_alu = w_a | w_b;
      4'd4:    w_alu = w_a ^ w_b;
      4'd5:    w_alu = w_a << w_b[4:0];
      4'd6:    w_alu = w_a >> w_b[4:0];
      4'd7:    w_alu = $unsigned($signed(w_a) >>> w_b[4:0]);
      4'd8:    w_alu = ($signed(w_a) < $signed(w_b)) ? 32'd1 : 32'd0;
      4'd9:    w_alu = (w_a < w_b) ? 32'd1 : 32'd0;
      4'd10:   w_alu = w_b;
      default: w_alu = 32'd0;
    endcase
  end

`ifdef MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [63:0] r_acc;
  logic [31:0] r_b_mag;
  logic [31:0] r_dividend;
  logic [1:0]  r_md_op;
  logic        r_neg;
  logic        r_a_neg;
  logic        r_div0;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic [31:0] w_div_sub;
  logic        w_div_ge;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_md_result;

  assign w_a_mag = w_a[31] ? (~w_a + 32'd1) : w_a;
  assign w_b_mag = w_b[31] ? (~w_b + 32'd1) : w_b;

  // Shift-add multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b_mag} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Restoring divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
  assign w_div_sub   = w_div_shift[31:0] - r_b_mag;
  assign w_div_next  = w_div_ge ? {w_div_sub, r_acc[30:0], 1'b1}
                                : {w_div_shift[31:0], r_acc[30:0], 1'b0};

  assign w_prod = r_neg   ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_neg   ? (~r_acc[31:0] + 32'd1)  : r_acc[31:0];
  assign w_rem  = r_a_neg ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  always_comb begin
    w_md_result = 32'd0;
    case (r_md_op)
      2'd0: w_md_result = w_prod[31:0];
      2'd1: w_md_result = w_prod[63:32];
      2'd2: w_md_result = r_div0 ? 32'hFFFF_FFFF : w_quo;
      2'd3: w_md_result = r_div0 ? r_dividend : w_rem;
      default: w_md_result = 32'd0;
    endcase
  end

  assign stall    = ((r_state == S_IDLE) && w_muldiv && !flush) || (r_state == S_BUSY);
  assign w_kill   = flush || ((r_state == S_IDLE) && w_muldiv) || (r_state == S_BUSY);
  assign w_result = (r_state == S_DONE) ? w_md_result : w_alu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= 5'd0;
      r_acc      <= 64'd0;
      r_b_mag    <= 32'd0;
      r_dividend <= 32'd0;
      r_md_op    <= 2'd0;
      r_neg      <= 1'b0;
      r_a_neg    <= 1'b0;
      r_div0     <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_count <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_muldiv) begin
            r_state    <= S_BUSY;
            r_count    <= 5'd0;
            r_acc      <= {32'd0, w_a_mag};
            r_b_mag    <= w_b_mag;
            r_dividend <= w_a;
            r_md_op    <= w_alu_op[1:0];
            r_neg      <= w_a[31] ^ w_b[31];
            r_a_neg    <= w_a[31];
            r_div0     <= (w_b == 32'd0);
          end
        end
        S_BUSY: begin
          r_acc   <= r_md_op[1] ? w_div_next : w_mul_next;
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign stall    = 1'b0;
  assign w_kill   = flush;
  assign w_result = w_muldiv ? 32'd0 : w_alu;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_out    <= 32'd0;
      r2_out            <= 32'd0;
      rd_out            <= 5'd0;
      op_data_out       <= 11'd0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= 32'd0;
    end else if (w_kill) begin
      alu_result_out    <= 32'd0;
      r2_out            <= 32'd0;
      rd_out            <= 5'd0;
      op_data_out       <= 11'd0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= 32'd0;
    end else begin
      alu_result_out    <= w_result;
      r2_out            <= r2;
      rd_out            <= rd;
      op_data_out       <= op_data;
      branch_taken_out  <= op_data[10] && (r1 == r2);
      branch_target_out <= PC + imm;
    end
  end

endmodule

// File: tb/tb_stage3_exec.sv
// Directed scoreboard bench for stage3_exec; muldiv sequences run when MULDIV_EN is defined.
module tb_stage3_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] r1, r2, imm, PC;
  logic [4:0]  rd;
  logic [10:0] op_data;
  logic        flush;
  logic        stall;
  logic [31:0] alu_result_out, r2_out, branch_target_out;
  logic [4:0]  rd_out;
  logic [10:0] op_data_out;
  logic        branch_taken_out;

  stage3_exec dut (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .rd(rd), .imm(imm), .PC(PC),
    .op_data(op_data), .flush(flush), .stall(stall),
    .alu_result_out(alu_result_out), .r2_out(r2_out), .rd_out(rd_out),
    .op_data_out(op_data_out), .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] r2v;
    logic [4:0]  rdv;
    logic [10:0] opv;
    logic        bt;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] opd(input logic [3:0] alu, input logic use_imm, input logic use_pc,
                                      input logic md, input logic br);
    return {br, 1'b0, 1'b0, 1'b1, md, use_pc, use_imm, alu};
  endfunction

  task automatic present(input logic [31:0] a, input logic [31:0] b, input logic [31:0] iv,
                         input logic [31:0] pcv, input logic [4:0] rdv, input logic [10:0] opv);
    r1 = a; r2 = b; imm = iv; PC = pcv; rd = rdv; op_data = opv;
  endtask

  task automatic push_exp(input logic [31:0] alu_v);
    exp_t e;
    e.alu = alu_v;
    e.r2v = r2;
    e.rdv = rd;
    e.opv = op_data;
    e.bt  = op_data[10] && (r1 == r2);
    e.tgt = PC + imm;
    sb.push_back(e);
  endtask

  task automatic step_check(input string tag);
    exp_t e;
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".alu"}, alu_result_out, e.alu);
    chk({tag, ".r2"},  r2_out, e.r2v);
    chk({tag, ".rd"},  {27'd0, rd_out}, {27'd0, e.rdv});
    chk({tag, ".op"},  {21'd0, op_data_out}, {21'd0, e.opv});
    chk({tag, ".bt"},  {31'd0, branch_taken_out}, {31'd0, e.bt});
    chk({tag, ".tgt"}, branch_target_out, e.tgt);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".b_alu"}, alu_result_out, 32'd0);
    chk({tag, ".b_op"},  {21'd0, op_data_out}, 32'd0);
    chk({tag, ".b_rd"},  {27'd0, rd_out}, 32'd0);
    chk({tag, ".b_tgt"}, branch_target_out, 32'd0);
  endtask

`ifdef MULDIV_EN
  task automatic md_check(input string tag);
    int n = 0;
    while (stall === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      chk({tag, ".bub_alu"}, alu_result_out, 32'd0);
      chk({tag, ".bub_op"},  {21'd0, op_data_out}, 32'd0);
      n++;
    end
    chk({tag, ".stall_cycles"}, n, 32'd33);
    step_check(tag);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0;
    present(32'h1234, 32'h55, 32'h10, 32'h200, 5'd3, opd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    chk_bubble("reset");
    chk("reset.r2", r2_out, 32'd0);
    chk("reset.bt", {31'd0, branch_taken_out}, 32'd0);
    chk("reset.stall", {31'd0, stall}, 32'd0);
    @(negedge clk) rst = 1'b1;

    present(32'd5, 32'd7, 32'd0, 32'd0, 5'd1, opd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd12); step_check("add");
    present(32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd2, opd(4'd7, 1'b1, 1'b0, 1'b0, 1'b0));
    push_exp(32'hF800_0000); step_check("sra_imm");
    present(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3, opd(4'd8, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd1); step_check("slt");
    present(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd4, opd(4'd9, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd0); step_check("sltu");
    present(32'd10, 32'd3, 32'd0, 32'd0, 5'd5, opd(4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd7); step_check("sub");
    present(32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd6, opd(4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'hF000); step_check("and");
    present(32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd7, opd(4'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'hFFF0); step_check("or");
    present(32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd8, opd(4'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'h0FF0); step_check("xor");
    present(32'd1, 32'd31, 32'd0, 32'd0, 5'd9, opd(4'd5, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'h8000_0000); step_check("sll");
    present(32'd3, 32'd33, 32'd0, 32'd0, 5'd10, opd(4'd5, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd6); step_check("sll_b40");
    present(32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd11, opd(4'd6, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'h0800_0000); step_check("srl");
    present(32'd1, 32'd2, 32'hDEAD_BEEF, 32'd0, 5'd12, opd(4'd10, 1'b1, 1'b0, 1'b0, 1'b0));
    push_exp(32'hDEAD_BEEF); step_check("passb");
    present(32'd5, 32'd7, 32'd0, 32'd0, 5'd13, opd(4'd11, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd0); step_check("op11");
    present(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 5'd14, opd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd1); step_check("add_wrap");
    present(32'd0, 32'd0, 32'h20, 32'h1000, 5'd15, opd(4'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    push_exp(32'h1020); step_check("pc_imm");
    present(32'd9, 32'd9, 32'hFFFF_FFF8, 32'h100, 5'd0, opd(4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    push_exp(32'd0); step_check("branch_taken");
    chk("branch.tgt_const", branch_target_out, 32'h0000_00F8);
    chk("branch.bt_const", {31'd0, branch_taken_out}, 32'd1);
    present(32'd9, 32'd8, 32'd4, 32'h100, 5'd0, opd(4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    push_exp(32'd1); step_check("branch_not");

    present(32'd5, 32'd7, 32'd4, 32'h40, 5'd9, opd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    flush = 1'b1;
    @(posedge clk); #1;
    chk_bubble("flush");
    flush = 1'b0;

`ifdef MULDIV_EN
    present(32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd16, opd(4'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'hFFFF_FFFD); md_check("div");
    present(32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd17, opd(4'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'hFFFF_FFFF); md_check("rem");
    present(32'd100, 32'd0, 32'd0, 32'd0, 5'd18, opd(4'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'hFFFF_FFFF); md_check("div0");
    present(32'd100, 32'd0, 32'd0, 32'd0, 5'd19, opd(4'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'd100); md_check("rem0");
    present(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd20, opd(4'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'h8000_0000); md_check("div_ovf");
    present(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd21, opd(4'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'd0); md_check("rem_ovf");
    present(32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 5'd22, opd(4'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'h4000_0000); md_check("mulh");
    present(32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 5'd23, opd(4'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'hFFFF_FFFF); md_check("mulh_neg");
    present(32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 5'd24, opd(4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'hFFFF_FFFD); md_check("mul");
    present(32'd20, 32'd22, 32'd0, 32'd0, 5'd25, opd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd42); step_check("add_after_mul");

    present(32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd26, opd(4'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    repeat (11) @(posedge clk);
    #1;
    chk("flush_busy.stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    chk_bubble("flush_busy");
    flush = 1'b0;
    present(32'd1, 32'd1, 32'd0, 32'd0, 5'd27, opd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd2); step_check("after_flush");

    present(32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd28, opd(4'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    repeat (21) @(posedge clk);
    #2 rst = 1'b0;
    present(32'd1, 32'd1, 32'd0, 32'd0, 5'd29, opd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    chk_bubble("rst_mid");
    chk("rst_mid.stall", {31'd0, stall}, 32'd0);
    @(negedge clk) rst = 1'b1;
    present(32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 5'd30, opd(4'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'hFFFF_FFFD); md_check("div_after_rst");
`else
    present(32'hFFFF_FFF9, 32'd2, 32'd8, 32'h30, 5'd16, opd(4'd2, 1'b0, 1'b0, 1'b1, 1'b0));
    push_exp(32'd0); step_check("md_off");
    present(32'd20, 32'd22, 32'd0, 32'd0, 5'd25, opd(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    push_exp(32'd42); step_check("add_after_md");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
